// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the mem_* request interface.
// Default field widths match the SDRAM controller this block stands in for.
package mem_if_pkg;

    typedef enum logic {
        SERVE   = 1'b0,
        REFRESH = 1'b1
    } resp_state_e;

    localparam int MEM_ADDR_W = 24;
    localparam int MEM_DATA_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-latency read return path: valid+data shift register.
// Data stages only load behind a valid bit, so the last stage holds.
module mem_read_pipe #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = dat_q[STAGES-1];

endmodule

// File: rtl/mem_responder.sv
// On-chip RAM responder for the mem_* interface with SDRAM-like
// slot cadence, fixed read latency and periodic refresh blackout.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH       = MEM_ADDR_W,
    parameter int DATA_WIDTH       = MEM_DATA_W,
    parameter int MEM_SIZE         = 65536,
    parameter int RDY_PERIOD       = 2,
    parameter int READ_LATENCY     = 3,
    parameter int REFRESH_INTERVAL = 390,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_rdy,
    output logic                  mem_cplt,
    output logic                  refresh_busy,
    output logic                  conflict_err
);

    localparam int IDX_WIDTH  = cnt_width(MEM_SIZE);
    localparam int SLOT_WIDTH = cnt_width(RDY_PERIOD);
    localparam int REF_WIDTH  =
        cnt_width(max_int(REFRESH_INTERVAL, REFRESH_CYCLES));

    localparam bit REF_EN = (REFRESH_INTERVAL != 0);
    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST =
        SLOT_WIDTH'(RDY_PERIOD - 1);
    localparam logic [REF_WIDTH-1:0] REF_LAST =
        REF_WIDTH'(REF_EN ? REFRESH_INTERVAL - 1 : 0);
    localparam logic [REF_WIDTH-1:0] BLK_LAST =
        REF_WIDTH'(REFRESH_CYCLES - 1);

    resp_state_e           state_q, state_d;
    logic [SLOT_WIDTH-1:0] slot_q, slot_d;
    logic [REF_WIDTH-1:0]  tmr_q, tmr_d;
    logic                  refresh_due;

    logic [IDX_WIDTH-1:0]  idx;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    assign idx = mem_addr[IDX_WIDTH-1:0];

    generate
        if (ADDR_WIDTH > IDX_WIDTH) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^mem_addr[ADDR_WIDTH-1:IDX_WIDTH];
        end
    endgenerate

    assign refresh_due = REF_EN && (state_q == SERVE) &&
                         (tmr_q == REF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SERVE;
            slot_q  <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            tmr_q   <= tmr_d;
        end
    end

    // The timer counts SERVE cycles, then is reused to time the blackout.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        tmr_d        = tmr_q;
        mem_rdy      = 1'b0;
        refresh_busy = 1'b0;
        unique case (state_q)
            SERVE: begin
                mem_rdy = (slot_q == SLOT_LAST) && !refresh_due;
                if (slot_q != SLOT_LAST) begin
                    slot_d = slot_q + SLOT_WIDTH'(1);
                end else if (!refresh_due) begin
                    slot_d = '0;
                end
                if (refresh_due) begin
                    state_d = REFRESH;
                    tmr_d   = '0;
                end else begin
                    tmr_d = REF_EN ? tmr_q + REF_WIDTH'(1) : '0;
                end
            end
            REFRESH: begin
                refresh_busy = 1'b1;
                if (tmr_q == BLK_LAST) begin
                    state_d = SERVE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + REF_WIDTH'(1);
                end
            end
            default: begin
                state_d = SERVE;
            end
        endcase
    end

    assign acc_wr = mem_rdy && mem_w_en;
    assign acc_rd = mem_rdy && mem_r_en && !mem_w_en;

    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem[idx] <= mem_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_err <= 1'b0;
        end else if (mem_rdy && mem_r_en && mem_w_en) begin
            conflict_err <= 1'b1;
        end
    end

    mem_read_pipe #(
        .STAGES (READ_LATENCY),
        .WIDTH  (DATA_WIDTH)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc_rd),
        .in_data   (mem[idx]),
        .out_valid (mem_cplt),
        .out_data  (mem_data_out)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: cadence, latency, aliasing,
// conflicts, refresh blackout and mid-flight reset.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_r;
    logic [23:0] addr, addr_r;
    logic [15:0] din, din_r;
    logic        r_en, w_en, r_en_r, w_en_r;
    logic [15:0] dout, dout_r;
    logic        rdy, cplt, busy, cerr;
    logic        rdy_r, cplt_r, busy_r, cerr_r;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;

    mem_responder #(
        .REFRESH_INTERVAL (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (addr),
        .mem_data_in  (din),
        .mem_r_en     (r_en),
        .mem_w_en     (w_en),
        .mem_data_out (dout),
        .mem_rdy      (rdy),
        .mem_cplt     (cplt),
        .refresh_busy (busy),
        .conflict_err (cerr)
    );

    mem_responder #(
        .REFRESH_INTERVAL (20),
        .REFRESH_CYCLES   (8)
    ) dut_r (
        .clk          (clk),
        .rst          (rst_r),
        .mem_addr     (addr_r),
        .mem_data_in  (din_r),
        .mem_r_en     (r_en_r),
        .mem_w_en     (w_en_r),
        .mem_data_out (dout_r),
        .mem_rdy      (rdy_r),
        .mem_cplt     (cplt_r),
        .refresh_busy (busy_r),
        .conflict_err (cerr_r)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_slot();
        int n = 0;
        while (!rdy && n < 8) begin
            tick();
            n++;
        end
        chk("slot_wait", 32'(rdy), 32'd1);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [15:0] d);
        wait_slot();
        addr = a;
        din  = d;
        w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, input logic [15:0] exp);
        wait_slot();
        addr = a;
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("rd_lat1", 32'(cplt), 32'd0);
        tick();
        chk("rd_lat2", 32'(cplt), 32'd0);
        tick();
        chk("rd_cplt", 32'(cplt), 32'd1);
        chk("rd_data", 32'(dout), 32'(exp));
        tick();
        chk("rd_pulse", 32'(cplt), 32'd0);
        chk("rd_hold", 32'(dout), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic exp_rdy;
        rst = 1'b1;   rst_r = 1'b1;
        addr = '0;    din = '0;    r_en = 1'b0;   w_en = 1'b0;
        addr_r = '0;  din_r = '0;  r_en_r = 1'b0; w_en_r = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_cplt", 32'(cplt), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cerr", 32'(cerr), 32'd0);

        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 10; c++) begin
            chk("rdy_cadence", 32'(rdy), 32'(c % 2));
            chk("idle_cplt", 32'(cplt), 32'd0);
            tick();
        end

        do_write(24'h000010, 16'h1234);
        do_read(24'h000010, 16'h1234);

        do_write(24'h010005, 16'hBEEF);
        do_read(24'h000005, 16'hBEEF);

        for (int i = 0; i < 4; i++) begin
            do_write(24'(i), 16'hC000 + 16'(i));
        end
        wait_slot();
        for (int k = 0; k < 11; k++) begin
            r_en = (k % 2 == 0) && (k <= 6);
            addr = 24'(k / 2);
            if (k % 2 == 0) chk("b2b_slot", 32'(rdy), 32'd1);
            chk("b2b_cplt", 32'(cplt),
                32'((k >= 3) && (k % 2 == 1) && (k <= 9)));
            if (cplt) chk("b2b_data", 32'(dout),
                          32'(16'hC000 + 16'((k - 3) / 2)));
            tick();
        end
        r_en = 1'b0;

        wait_slot();
        addr = 24'h000020;
        din  = 16'h00AA;
        r_en = 1'b1;
        w_en = 1'b1;
        tick();
        r_en = 1'b0;
        w_en = 1'b0;
        chk("conflict_set", 32'(cerr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("conflict_nocplt", 32'(cplt), 32'd0);
            tick();
        end
        chk("conflict_sticky", 32'(cerr), 32'd1);
        do_read(24'h000020, 16'h00AA);
        chk("conflict_still", 32'(cerr), 32'd1);

        wait_slot();
        addr = 24'h0;
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        tick();
        chk("inflight_slot", 32'(rdy), 32'd1);
        addr = 24'h1;
        r_en = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        r_en = 1'b0;
        tick();
        chk("mrst_cplt", 32'(cplt), 32'd0);
        chk("mrst_rdy", 32'(rdy), 32'd0);
        chk("mrst_cerr", 32'(cerr), 32'd0);
        tick();
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 8; c++) begin
            chk("post_rst_rdy", 32'(rdy), 32'(c % 2));
            chk("post_rst_cplt", 32'(cplt), 32'd0);
            tick();
        end
        chk("post_rst_cerr", 32'(cerr), 32'd0);

        rst_r = 1'b0;
        cyc = 0;
        for (int c = 0; c < 58; c++) begin
            w_en_r = (c == 1);
            r_en_r = (c == 17) || (c == 46);
            addr_r = 24'h000007;
            din_r  = 16'h5A5A;
            exp_rdy = (c <= 17 && c % 2 == 1) ||
                      (c >= 28 && c <= 46 && c % 2 == 0) || (c == 56);
            chk("ref_busy", 32'(busy_r),
                32'(((c >= 20) && (c < 28)) || ((c >= 48) && (c < 56))));
            chk("ref_rdy", 32'(rdy_r), 32'(exp_rdy));
            chk("ref_cplt", 32'(cplt_r), 32'((c == 20) || (c == 49)));
            if (c == 20 || c == 49) chk("ref_data", 32'(dout_r), 32'h5A5A);
            tick();
        end
        w_en_r = 1'b0;
        r_en_r = 1'b0;
        chk("ref_cerr", 32'(cerr_r), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
